fetch_stage: RTL and testbench

// - IF stage plus IF/ID pipeline register of the 5-stage MIPS core. Feeds D-stage operands to the hazard unit.
// - Consumes stallF/stallD from the hazard unit and branch/jump redirects from EX.
// - Issues in-order requests to a variable-latency instruction memory (req/gnt, rvalid).
// - Buffers responses so that a stall never loses a fetched instruction.

---
 rtl/fetch_stage_pkg.sv | 25 ++
 rtl/fetch_buffer.sv | 51 +++++
 rtl/fetch_stage.sv | 129 ++++++++++++
 tb/tb_fetch_stage.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared fetch-stage definitions: enable levels, NOP encoding, buffer entry and IF/ID record.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fetch_stage_pkg;

  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  // One fetched instruction together with the address it came from.
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

  // Contents of the IF/ID pipeline register as seen by decode.
  typedef struct packed {
    logic        D_valid;
    logic [31:0] D_instr;
    logic [31:0] D_pc;
    logic [31:0] D_pc_plus4;
  } Fetch_output;

endpackage

// File: rtl/fetch_buffer.sv
// Small synchronous FIFO holding fetched instructions until the IF/ID register can take them.
// Latency: a pushed entry is visible at head on the next cycle.
// Backpressure: none; the caller guarantees it never pushes into a full buffer. Flush beats push.
module fetch_buffer
  import fetch_stage_pkg::*;
#(
  parameter int BUF_DEPTH = 2,
  localparam int PW = $clog2(BUF_DEPTH),
  localparam int CW = PW + 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  fetch_entry_t data,
  input  logic         pop,
  input  logic         flush,
  output fetch_entry_t head,
  output logic [CW-1:0] count
);

  fetch_entry_t  mem [BUF_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  assign head = mem[rd_ptr];

  // Storage write; a flushed push is simply never made visible.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[wr_ptr] <= data;
    end
  end

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + PW'(push);
      rd_ptr <= rd_ptr + PW'(pop);
      count  <= count + CW'(push) - CW'(pop);
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// MIPS IF stage plus IF/ID register: in-order imem requests, response buffering, branch redirect.
// Latency: with a 1-cycle memory an instruction reaches D_* two edges after its request is accepted.
// Backpressure: stallF/stallD and a credit limit hold requests so the buffer can never overflow.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter int                INSTR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter int                BUF_DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stallF,
  input  logic               stallD,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_gnt,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               D_valid,
  output logic [INSTR_W-1:0] D_instr,
  output logic [ADDR_W-1:0]  D_pc,
  output logic [ADDR_W-1:0]  D_pc_plus4
);

  localparam int CW = $clog2(BUF_DEPTH) + 1;

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] resp_pc_q;
  logic [CW-1:0]     out_cnt;
  logic [CW-1:0]     drop_cnt;
  logic [CW-1:0]     buf_cnt;
  logic              en_q;
  logic              accept;
  logic              rsp;
  logic              buf_push;
  logic              buf_pop;
  logic [CW:0]       slots_used;
  logic [ADDR_W-1:0] redirect_aligned;
  fetch_entry_t      buf_head;
  fetch_entry_t      buf_data;
  Fetch_output       d_q;

  // A response with nothing outstanding is a leftover from before reset.
  assign rsp      = imem_rvalid && (out_cnt != '0);
  assign buf_pop  = (stallD == DISABLE) && (buf_cnt != '0) && !redirect_valid;
  assign buf_push = rsp && (drop_cnt == '0) && !redirect_valid;
  assign buf_data = '{instr: imem_rdata, pc: resp_pc_q};

  // Slots still committed after this edge; the entry decode takes this cycle frees one,
  // which is what lets a 2-deep buffer sustain one instruction per cycle.
  assign slots_used = {1'b0, out_cnt} + {1'b0, buf_cnt} - (CW+1)'(buf_pop);

  assign imem_req  = en_q && (stallF == DISABLE) && !redirect_valid &&
                     (slots_used < (CW+1)'(BUF_DEPTH));
  assign imem_addr = pc_q;
  assign accept    = imem_req && imem_gnt;

  assign redirect_aligned = {redirect_pc[ADDR_W-1:2], 2'b00};

  fetch_buffer #(.BUF_DEPTH(BUF_DEPTH)) u_buf (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (buf_push),
    .data  (buf_data),
    .pop   (buf_pop),
    .flush (redirect_valid),
    .head  (buf_head),
    .count (buf_cnt)
  );

  // Hold off requests for the first cycle after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) en_q <= DISABLE;
    else        en_q <= ENABLE;
  end

  // Fetch PC, response PC and outstanding/drop accounting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q      <= RESET_PC;
      resp_pc_q <= RESET_PC;
      out_cnt   <= '0;
      drop_cnt  <= '0;
    end else if (redirect_valid) begin
      // Everything still in flight belongs to the wrong path; this cycle's beat is dropped directly.
      pc_q      <= redirect_aligned;
      resp_pc_q <= redirect_aligned;
      out_cnt   <= out_cnt - CW'(rsp);
      drop_cnt  <= out_cnt - CW'(rsp);
    end else begin
      if (accept) pc_q <= pc_q + ADDR_W'(4);
      out_cnt <= out_cnt + CW'(accept) - CW'(rsp);
      if (rsp) begin
        if (drop_cnt != '0) drop_cnt  <= drop_cnt - CW'(1);
        else                resp_pc_q <= resp_pc_q + ADDR_W'(4);
      end
    end
  end

  // IF/ID register: redirect squashes, stallD holds, otherwise load head or insert a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_q <= '{D_valid: 1'b0, D_instr: NOP_INSTR, D_pc: '0, D_pc_plus4: '0};
    end else if (redirect_valid) begin
      d_q.D_valid <= 1'b0;
      d_q.D_instr <= NOP_INSTR;
    end else if (stallD == DISABLE) begin
      if (buf_cnt != '0) begin
        d_q.D_valid    <= 1'b1;
        d_q.D_instr    <= buf_head.instr;
        d_q.D_pc       <= buf_head.pc;
        d_q.D_pc_plus4 <= buf_head.pc + 32'd4;
      end else begin
        d_q.D_valid <= 1'b0;
        d_q.D_instr <= NOP_INSTR;
      end
    end
  end

  assign D_valid    = d_q.D_valid;
  assign D_instr    = d_q.D_instr;
  assign D_pc       = d_q.D_pc;
  assign D_pc_plus4 = d_q.D_pc_plus4;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: variable-latency memory model plus in-order scoreboard.
// Expected D_* stream is queued by the stimulus; a negedge monitor pops it on every new load.
// Directed checks cover reset, stalls, redirect, grant stalls, buffer fill and async reset.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stallF = 1'b0;
  logic        stallD = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b1;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        D_valid;
  logic [31:0] D_instr;
  logic [31:0] D_pc;
  logic [31:0] D_pc_plus4;

  fetch_stage #(.ADDR_W(32), .INSTR_W(32), .RESET_PC(32'h0), .BUF_DEPTH(2)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stallF         (stallF),
    .stallD         (stallD),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .D_valid        (D_valid),
    .D_instr        (D_instr),
    .D_pc           (D_pc),
    .D_pc_plus4     (D_pc_plus4)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int lat = 1;
  int ncyc = 0;
  logic ld_q = 1'b0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;
  pend_t pend[$];

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return 32'hC0DE_0000 ^ a;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic nxt();
    @(negedge clk);
    #2;
  endtask

  task automatic push_seq(input logic [31:0] start, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(start + 32'(4 * i));
  endtask

  task automatic wait_dvalid(input string name, input int budget);
    int k;
    k = 0;
    while (!D_valid && k < budget) begin
      nxt();
      k++;
    end
    if (!D_valid) begin
      checks++;
      errors++;
      $display("FAIL %s: D_valid never rose within %0d cycles", name, budget);
    end
  endtask

  // Memory model: in-order, fixed latency 'lat' counted from the accept cycle.
  always @(posedge clk) begin
    if (imem_req && imem_gnt) pend.push_back('{addr: imem_addr, due: ncyc + lat - 1});
    if (pend.size() > 0 && pend[0].due <= ncyc) begin
      imem_rvalid <= 1'b1;
      imem_rdata  <= instr_of(pend[0].addr);
      void'(pend.pop_front());
    end else begin
      imem_rvalid <= 1'b0;
      imem_rdata  <= 32'h0;
    end
    ncyc = ncyc + 1;
  end

  // Remember whether the IF/ID register was allowed to load at this edge.
  always @(posedge clk) ld_q = !stallD;

  // Monitor: every freshly loaded valid instruction must match the queue head.
  always @(negedge clk) begin : monitor
    logic [31:0] e;
    if (rst_n && D_valid && ld_q) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_load: got D_pc %h expected no instruction", D_pc);
      end else begin
        e = exp_q.pop_front();
        chk("sb_d_pc", D_pc, e);
        chk("sb_d_instr", D_instr, instr_of(e));
        chk("sb_d_pc_plus4", D_pc_plus4, e + 32'd4);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] p0;
    logic [31:0] i0;
    logic [31:0] a0;

    // Reset held for 5 cycles.
    repeat (5) nxt();
    chk("rst_req", 32'(imem_req), 32'h0);
    chk("rst_d_valid", 32'(D_valid), 32'h0);
    chk("rst_d_instr", D_instr, 32'h0);
    chk("rst_d_pc", D_pc, 32'h0);
    push_seq(32'h0, 24);
    rst_n = 1'b1;
    nxt();
    chk("post_rst_req", 32'(imem_req), 32'h1);
    chk("post_rst_addr", imem_addr, 32'h0);
    chk("post_rst_d_valid", 32'(D_valid), 32'h0);
    chk("post_rst_d_instr", D_instr, 32'h0);

    // Straight line, 1-cycle memory: 8 instructions on consecutive cycles.
    wait_dvalid("first_fetch", 10);
    for (int i = 0; i < 8; i++) begin
      chk("straight_valid", 32'(D_valid), 32'h1);
      chk("straight_pc", D_pc, 32'(4 * i));
      nxt();
    end

    // Both stalls for 3 cycles: D frozen, no requests.
    p0 = D_pc;
    i0 = D_instr;
    stallF = 1'b1;
    stallD = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_req", 32'(imem_req), 32'h0);
      nxt();
      chk("stall_d_pc", D_pc, p0);
      chk("stall_d_instr", D_instr, i0);
    end
    stallF = 1'b0;
    stallD = 1'b0;
    repeat (4) nxt();

    // Redirect to a misaligned target with two requests in flight at 3-cycle latency.
    lat = 3;
    repeat (8) nxt();
    exp_q.delete();
    push_seq(32'h100, 64);
    redirect_valid = 1'b1;
    redirect_pc = 32'h103;
    #1;
    chk("redirect_cycle_req", 32'(imem_req), 32'h0);
    nxt();
    redirect_valid = 1'b0;
    #1;
    chk("redirect_d_valid", 32'(D_valid), 32'h0);
    chk("redirect_req", 32'(imem_req), 32'h1);
    chk("redirect_addr", imem_addr, 32'h100);
    wait_dvalid("redirect_first", 20);
    chk("redirect_first_pc", D_pc, 32'h100);
    chk("redirect_first_instr", D_instr, instr_of(32'h100));

    // Grant withheld for 4 cycles: request held with a stable address.
    lat = 1;
    repeat (6) nxt();
    imem_gnt = 1'b0;
    #1;
    a0 = imem_addr;
    for (int i = 0; i < 4; i++) begin
      chk("nogrant_req", 32'(imem_req), 32'h1);
      chk("nogrant_addr", imem_addr, a0);
      nxt();
      #1;
    end
    imem_gnt = 1'b1;
    repeat (4) nxt();

    // Decode stalled: buffer fills to two, requests stop, then two drain in order.
    p0 = D_pc;
    stallD = 1'b1;
    repeat (3) nxt();
    chk("buf_full_req", 32'(imem_req), 32'h0);
    chk("buf_full_d_pc", D_pc, p0);
    stallD = 1'b0;
    nxt();
    chk("drain1_valid", 32'(D_valid), 32'h1);
    chk("drain1_pc", D_pc, p0 + 32'd4);
    nxt();
    chk("drain2_valid", 32'(D_valid), 32'h1);
    chk("drain2_pc", D_pc, p0 + 32'd8);

    // Asynchronous reset mid-stream with slow responses still in flight.
    lat = 3;
    repeat (5) nxt();
    rst_n = 1'b0;
    #1;
    chk("arst_req", 32'(imem_req), 32'h0);
    chk("arst_d_valid", 32'(D_valid), 32'h0);
    chk("arst_d_instr", D_instr, 32'h0);
    chk("arst_d_pc", D_pc, 32'h0);
    chk("arst_d_pc_plus4", D_pc_plus4, 32'h0);
    exp_q.delete();
    push_seq(32'h0, 16);
    imem_gnt = 1'b0;
    nxt();
    rst_n = 1'b1;
    repeat (6) nxt();
    chk("stale_ignored", 32'(D_valid), 32'h0);
    lat = 1;
    imem_gnt = 1'b1;
    wait_dvalid("post_arst_first", 10);
    chk("post_arst_pc", D_pc, 32'h0);
    repeat (10) nxt();

    stallF = 1'b1;
    repeat (4) nxt();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
